// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per request over a
// req/ready handshake and holds it for the control unit until consumed.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned-target trap + HALT).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCsrc,
   input  logic [31:0] ImmOp,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] PC
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        req_q;
   logic [31:0] addr_q;
   logic [31:0] pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_q;
`endif

   // Next PC on consume: branch target or sequential, carries dropped
   always_comb begin
      pc_d = PCsrc ? (pc_q + ImmOp) : (pc_q + PC_INC);
`ifndef FETCH_MISALIGN_TRAP_EN
      pc_d = pc_d & 32'hFFFF_FFFC;
`endif
   end

   // Fetch FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= NOP;
         valid_q    <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               req_q   <= 1'b1;
               addr_q  <= pc_q;
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (imem_ready) begin
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pc_q    <= pc_d;
                  valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (pc_d[1:0] != 2'b00) begin
                     misalign_q <= 1'b1;
                     state_q    <= S_HALT;
                  end else begin
                     req_q   <= 1'b1;
                     addr_q  <= pc_d;
                     state_q <= S_REQ;
                  end
`else
                  req_q   <= 1'b1;
                  addr_q  <= pc_d;
                  state_q <= S_REQ;
`endif
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
`endif
            default: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign PC          = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// Memory model returns the requested address as the instruction word.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PCsrc = 1'b0;
   logic [31:0] ImmOp = 32'h0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b1;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] PC;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .PC          (PC)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign    (misalign)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      imem_ready = 1'b1;
      tick();
      tick();
      n_cmp += 5;
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL rst_req got %b want 0", imem_req);
      end
      if (instr_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_valid got %b want 0", instr_valid);
      end
      if (imem_addr !== 32'h0) begin
         n_err++; $display("FAIL rst_addr got %h want 0", imem_addr);
      end
      if (PC !== 32'h0) begin
         n_err++; $display("FAIL rst_pc got %h want 0", PC);
      end
      if (instr !== 32'h0000_0013) begin
         n_err++; $display("FAIL rst_instr got %h want 00000013", instr);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_cmp++;
      if (misalign !== 1'b0) begin
         n_err++; $display("FAIL rst_misalign got %b want 0", misalign);
      end
`endif
   endtask

   task automatic test_sequential;
      logic [31:0] a;
      rst = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         a = 32'(4 * k);
         n_cmp += 3;
         if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL seq_req got %b want 1", imem_req);
         end
         if (imem_addr !== a) begin
            n_err++; $display("FAIL seq_addr got %h want %h", imem_addr, a);
         end
         if (instr_valid !== 1'b0) begin
            n_err++; $display("FAIL seq_novalid got %b want 0", instr_valid);
         end
         tick();
         n_cmp += 4;
         if (instr_valid !== 1'b1) begin
            n_err++; $display("FAIL seq_valid got %b want 1", instr_valid);
         end
         if (instr !== a) begin
            n_err++; $display("FAIL seq_instr got %h want %h", instr, a);
         end
         if (PC !== a) begin
            n_err++; $display("FAIL seq_pc got %h want %h", PC, a);
         end
         if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL seq_req_hold got %b want 0", imem_req);
         end
         tick();
      end
   endtask

   task automatic test_wait;
      imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp += 3;
         if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL wait_req got %b want 1", imem_req);
         end
         if (imem_addr !== 32'h8) begin
            n_err++; $display("FAIL wait_addr got %h want 8", imem_addr);
         end
         if (instr_valid !== 1'b0) begin
            n_err++; $display("FAIL wait_valid got %b want 0", instr_valid);
         end
      end
      imem_ready = 1'b1;
      tick();
      n_cmp += 2;
      if (instr_valid !== 1'b1) begin
         n_err++; $display("FAIL wait_cap_valid got %b want 1", instr_valid);
      end
      if (instr !== 32'h8) begin
         n_err++; $display("FAIL wait_cap_instr got %h want 8", instr);
      end
      tick();
      n_cmp++;
      if (imem_addr !== 32'hC) begin
         n_err++; $display("FAIL seq_addr_c got %h want c", imem_addr);
      end
      tick();
      n_cmp++;
      if (instr !== 32'hC) begin
         n_err++; $display("FAIL seq_instr_c got %h want c", instr);
      end
      tick();
      n_cmp++;
      if (imem_addr !== 32'h10) begin
         n_err++; $display("FAIL seq_addr_10 got %h want 10", imem_addr);
      end
      tick();
   endtask

   task automatic test_branch;
      logic        vs [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] vi [5] = '{32'hFFFF_FFF8, 32'h8, 32'h20,
                              32'hFFFF_FFE0, 32'hDEAD_BEEF};
      logic [31:0] ve [5] = '{32'h08, 32'h10, 32'h30, 32'h10, 32'h14};
      for (int i = 0; i < 5; i++) begin
         PCsrc = vs[i];
         ImmOp = vi[i];
         tick();
         PCsrc = 1'b0;
         n_cmp += 2;
         if (imem_addr !== ve[i]) begin
            n_err++; $display("FAIL br_addr[%0d] got %h want %h", i, imem_addr, ve[i]);
         end
         if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL br_req[%0d] got %b want 1", i, imem_req);
         end
         tick();
         n_cmp++;
         if (PC !== ve[i]) begin
            n_err++; $display("FAIL br_pc[%0d] got %h want %h", i, PC, ve[i]);
         end
      end
   endtask

   task automatic test_stall;
      stall = 1'b1;
      PCsrc = 1'b1;
      ImmOp = 32'h100;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp += 4;
         if (instr_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_valid got %b want 1", instr_valid);
         end
         if (PC !== 32'h14) begin
            n_err++; $display("FAIL stall_pc got %h want 14", PC);
         end
         if (instr !== 32'h14) begin
            n_err++; $display("FAIL stall_instr got %h want 14", instr);
         end
         if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL stall_req got %b want 0", imem_req);
         end
      end
      stall = 1'b0;
      PCsrc = 1'b0;
      tick();
      n_cmp++;
      if (imem_addr !== 32'h18) begin
         n_err++; $display("FAIL stall_next got %h want 18", imem_addr);
      end
      tick();
   endtask

   task automatic test_wrap;
      PCsrc = 1'b1;
      ImmOp = 32'hFFFF_FFE4;
      tick();
      PCsrc = 1'b0;
      n_cmp++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_top got %h want fffffffc", imem_addr);
      end
      tick();
      tick();
      n_cmp++;
      if (imem_addr !== 32'h0) begin
         n_err++; $display("FAIL wrap_zero got %h want 0", imem_addr);
      end
      tick();
   endtask

   task automatic test_reset_midreq;
      tick();
      rst = 1'b1;
      tick();
      n_cmp += 4;
      if (instr_valid !== 1'b0) begin
         n_err++; $display("FAIL mrst_valid got %b want 0", instr_valid);
      end
      if (PC !== 32'h0) begin
         n_err++; $display("FAIL mrst_pc got %h want 0", PC);
      end
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL mrst_req got %b want 0", imem_req);
      end
      if (instr !== 32'h0000_0013) begin
         n_err++; $display("FAIL mrst_instr got %h want 00000013", instr);
      end
      rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_align;
      PCsrc = 1'b1;
      ImmOp = 32'h6;
      tick();
      PCsrc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         n_cmp += 4;
         if (misalign !== 1'b1) begin
            n_err++; $display("FAIL mis_flag got %b want 1", misalign);
         end
         if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL mis_req got %b want 0", imem_req);
         end
         if (instr_valid !== 1'b0) begin
            n_err++; $display("FAIL mis_valid got %b want 0", instr_valid);
         end
         if (PC !== 32'h6) begin
            n_err++; $display("FAIL mis_pc got %h want 6", PC);
         end
         tick();
      end
`else
      n_cmp += 2;
      if (imem_addr !== 32'h4) begin
         n_err++; $display("FAIL align_addr got %h want 4", imem_addr);
      end
      if (imem_req !== 1'b1) begin
         n_err++; $display("FAIL align_req got %b want 1", imem_req);
      end
      tick();
      n_cmp++;
      if (PC !== 32'h4) begin
         n_err++; $display("FAIL align_pc got %h want 4", PC);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait();
      test_branch();
      test_stall();
      test_wrap();
      test_reset_midreq();
      test_align();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
